// File: rtl/vram_arbiter.sv
// Text VRAM arbiter: fixed-schedule display fetches always win the port,
// CPU reads/writes fill the remaining cycles through a req/ack FSM.
module vram_arbiter #(
  parameter int          COLS           = 80,
  parameter logic [11:0] BASE_ADDR      = 12'h000,
  parameter bit          CPU_BLANK_ONLY = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        active,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [11:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  disp_data,
  output logic        disp_valid
);

  typedef enum logic [1:0] {
    IDLE,
    MEM,
    RD,
    ACK
  } state_t;

  localparam logic [11:0] COLS_W = 12'(COLS);

  state_t      state_q;
  logic        rd_q;
  logic        cpu_ack_q;
  logic [7:0]  cpu_rdata_q;
  logic        mem_en_q;
  logic        mem_we_q;
  logic [11:0] mem_addr_q;
  logic [7:0]  mem_wdata_q;
  logic        tag1_q;
  logic        tag2_q;
  logic [7:0]  disp_data_q;
  logic        disp_valid_q;

  logic [11:0] row_w;
  logic [11:0] row_off;
  logic [11:0] disp_addr;
  logic        slot;
  logic        blank_ok;
  logic        grant;
  logic        mem_en_d;
  logic        mem_we_d;
  logic [11:0] mem_addr_d;
  logic [7:0]  mem_wdata_d;

  assign row_w = {7'b0, y[8:4]};

  // 80 columns reduces to two shifts and an add; other widths multiply
  assign row_off = (COLS == 80) ? ((row_w << 6) + (row_w << 4))
                                : (row_w * COLS_W);

  assign disp_addr = BASE_ADDR + row_off + {5'b0, x[9:3]};

  assign slot = (x[2:0] == 3'd0) && (x < 10'd640) && (y < 10'd480);

  assign blank_ok = !(CPU_BLANK_ONLY && active);

  assign grant = (state_q == IDLE) && cpu_req && !slot && blank_ok;

  always_comb begin
    mem_en_d    = slot | grant;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (slot) begin
      mem_addr_d = disp_addr;
    end else if (grant) begin
      mem_we_d    = cpu_we;
      mem_addr_d  = cpu_addr;
      mem_wdata_d = cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rd_q         <= 1'b0;
      cpu_ack_q    <= 1'b0;
      cpu_rdata_q  <= 8'h00;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 12'h000;
      mem_wdata_q  <= 8'h00;
      tag1_q       <= 1'b0;
      tag2_q       <= 1'b0;
      disp_data_q  <= 8'h00;
      disp_valid_q <= 1'b0;
    end else begin
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      tag1_q       <= slot;
      tag2_q       <= tag1_q;
      disp_valid_q <= tag2_q;
      if (tag2_q) begin
        disp_data_q <= mem_rdata;
      end
      cpu_ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant) begin
            state_q <= MEM;
            rd_q    <= !cpu_we;
          end
        end
        MEM: begin
          state_q <= RD;
        end
        RD: begin
          state_q   <= ACK;
          cpu_ack_q <= 1'b1;
          if (rd_q) begin
            cpu_rdata_q <= mem_rdata;
          end
        end
        ACK: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cpu_ack    = cpu_ack_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;

endmodule
